// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - key codes, debounce FSM states and the 4x3 key map
package keypad_pkg;

  localparam logic [3:0] STAR  = 4'd10;
  localparam logic [3:0] HASH  = 4'd11;
  localparam logic [3:0] MULTI = 4'd14;
  localparam logic [3:0] NONE  = 4'd15;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} deb_state_e;

  // Indexed [row][column], columns left to right
  localparam logic [3:0] KEY_MAP [4][3] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{STAR, 4'd0, HASH}
  };

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key matrix drive/sense and key event outputs
interface keypad_scanner_if;

  logic [2:0] col_drv;
  logic [3:0] row_in;
  logic [3:0] key;
  logic       pressed;
  logic       set_code;

  modport master (output col_drv, key, pressed, set_code, input row_in);
  modport slave  (input col_drv, key, pressed, set_code, output row_in);

endinterface

// File: rtl/keypad_col_scan.sv
// rtl/keypad_col_scan.sv - one-hot column drive with dwell counter
// sample_o marks the last dwell cycle of column col_o.
module keypad_col_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] col_drv_o,
  output logic       sample_o,
  output logic [1:0] col_o
);

  logic [7:0] dwell_q, dwell_d;
  logic [1:0] col_q, col_d;

  assign sample_o  = (dwell_q == 8'(SCAN_DIV - 1));
  assign col_drv_o = 3'b001 << col_q;
  assign col_o     = col_q;

  always_comb begin
    dwell_d = sample_o ? 8'd0 : dwell_q + 8'd1;
    col_d   = col_q;
    if (sample_o) col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= 8'd0;
      col_q   <= 2'd0;
    end else begin
      dwell_q <= dwell_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad scanner: frame classifier and debounce FSM
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kif
);

  logic [2:0] col_drv;
  logic       sample;
  logic [1:0] col;

  keypad_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
    .clk       (clk),
    .rst       (rst),
    .col_drv_o (col_drv),
    .sample_o  (sample),
    .col_o     (col)
  );

  logic [1:0] acc_hits_q, acc_hits_d;
  logic [3:0] acc_code_q, acc_code_d;
  logic [2:0] col_hits, total_hits;
  logic [3:0] col_code, frame_code;
  logic       frame_done, accept;

  deb_state_e state_q;
  logic [3:0] cand_q, cnt_q, key_q;
  logic       pressed_q, set_code_q;

  // Hit count saturates at 2: only "none / one / more" matters for a frame
  always_comb begin
    col_hits = 3'd0;
    col_code = NONE;
    for (int r = 0; r < 4; r++) begin
      if (kif.row_in[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = KEY_MAP[r][col];
      end
    end
    total_hits = {1'b0, acc_hits_q} + col_hits;
    if (total_hits == 3'd0)      frame_code = NONE;
    else if (total_hits == 3'd1) frame_code = (acc_hits_q == 2'd1) ? acc_code_q : col_code;
    else                         frame_code = MULTI;
    frame_done = sample && (col == 2'd2);
    acc_hits_d = acc_hits_q;
    acc_code_d = acc_code_q;
    if (frame_done) begin
      acc_hits_d = 2'd0;
      acc_code_d = NONE;
    end else if (sample) begin
      acc_hits_d = (total_hits > 3'd2) ? 2'd2 : total_hits[1:0];
      if (col_hits != 3'd0) acc_code_d = col_code;
    end
  end

  assign accept = frame_done &&
                  (((state_q == IDLE) && (frame_code <= HASH) && (DEBOUNCE == 1)) ||
                   ((state_q == CONFIRM) && (frame_code == cand_q) &&
                    (cnt_q + 4'd1 == 4'(DEBOUNCE))));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cand_q     <= NONE;
      cnt_q      <= 4'd0;
      key_q      <= 4'd0;
      pressed_q  <= 1'b0;
      set_code_q <= 1'b0;
      acc_hits_q <= 2'd0;
      acc_code_q <= NONE;
    end else begin
      acc_hits_q <= acc_hits_d;
      acc_code_q <= acc_code_d;
      pressed_q  <= accept && (frame_code <= 4'd9);
      set_code_q <= accept && (frame_code == HASH);
      if (accept && (frame_code <= 4'd9)) key_q <= frame_code;
      if (frame_done) begin
        case (state_q)
          IDLE: if (frame_code <= HASH) begin
            cand_q  <= frame_code;
            cnt_q   <= 4'd1;
            state_q <= accept ? HELD : CONFIRM;
          end
          CONFIRM: begin
            if (frame_code != cand_q) begin
              state_q <= IDLE;
              cnt_q   <= 4'd0;
            end else if (accept) begin
              state_q <= HELD;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          HELD: if (frame_code == NONE) begin
            state_q <= (DEBOUNCE == 1) ? IDLE : RELEASE;
            cnt_q   <= (DEBOUNCE == 1) ? 4'd0 : 4'd1;
          end
          RELEASE: begin
            if (frame_code != NONE) begin
              state_q <= HELD;
              cnt_q   <= 4'd0;
            end else if (cnt_q + 4'd1 == 4'(DEBOUNCE)) begin
              state_q <= IDLE;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign kif.col_drv  = col_drv;
  assign kif.key      = key_q;
  assign kif.pressed  = pressed_q;
  assign kif.set_code = set_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - keypad_scanner bench: segment table, key-matrix model, pulse scoreboard
module tb_keypad_scanner;

  localparam int FRAME = 12;

  typedef struct {
    bit         hash;
    logic [3:0] key;
    int         cyc;
  } kexp_t;

  typedef struct {
    logic [11:0] keys;
    int          frames;
    int          pf;
    bit          hash;
    logic [3:0]  key;
  } seg_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] keys = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  bit          prev_pulse = 1'b0;
  logic [3:0]  last_digit = 4'd0;
  kexp_t       sb[$];
  seg_t        tbl[$];

  keypad_scanner_if kif ();

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always_comb begin
    kif.row_in = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (kif.col_drv[c] && keys[r*3+c]) kif.row_in[r] = 1'b1;
  end

  function automatic logic [11:0] km(int d);
    logic [11:0] m;
    m = '0;
    if (d == 0)       m[10] = 1'b1;
    else if (d == 10) m[9] = 1'b1;
    else if (d == 11) m[11] = 1'b1;
    else              m[d-1] = 1'b1;
    return m;
  endfunction

  function automatic seg_t mk(logic [11:0] k, int frames, int pf, bit hash, int key);
    seg_t s;
    s.keys = k; s.frames = frames; s.pf = pf; s.hash = hash; s.key = 4'(key);
    return s;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic run_seg(seg_t s);
    kexp_t e;
    keys = s.keys;
    if (s.pf > 0) begin
      e.hash = s.hash;
      e.key  = s.key;
      e.cyc  = cyc + s.pf * FRAME;
      sb.push_back(e);
      if (!s.hash) last_digit = s.key;
    end
    repeat (s.frames * FRAME) @(posedge clk);
    #1;
    chk("key_hold", kif.key, last_digit);
  endtask

  always @(negedge clk) begin : mon
    kexp_t e;
    bit    pulse;
    if (mon_en) begin
      pulse = kif.pressed || kif.set_code;
      n_checks++;
      if (!$onehot(kif.col_drv) || (kif.pressed && kif.set_code) || (pulse && prev_pulse) || (kif.key > 4'd9)) begin
        n_fail++;
        $display("FAIL invariant cyc=%0d: col_drv=%b pressed=%b set_code=%b prev_pulse=%b key=%0d; expected one-hot col_drv, exclusive single-cycle pulses, key<=9",
                 cyc, kif.col_drv, kif.pressed, kif.set_code, prev_pulse, kif.key);
      end
      prev_pulse = pulse;
      if (pulse) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse cyc=%0d: pressed=%b set_code=%b key=%0d, expected no pulse",
                   cyc, kif.pressed, kif.set_code, kif.key);
        end else begin
          e = sb.pop_front();
          if (kif.set_code !== e.hash || kif.pressed !== !e.hash || kif.key !== e.key || cyc != e.cyc) begin
            n_fail++;
            $display("FAIL pulse: got set_code=%b key=%0d at cyc %0d, expected set_code=%b key=%0d at cyc %0d",
                     kif.set_code, kif.key, cyc, e.hash, e.key, e.cyc);
          end
        end
      end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL pulse_missing: no pulse by cyc %0d, expected set_code=%b key=%0d at cyc %0d",
                 cyc, sb[0].hash, sb[0].key, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    tbl.push_back(mk(km(5), 20, 3, 0, 5));
    tbl.push_back(mk('0, 4, 0, 0, 0));
    tbl.push_back(mk(km(5), 2, 0, 0, 0));
    tbl.push_back(mk('0, 1, 0, 0, 0));
    tbl.push_back(mk(km(5), 3, 3, 0, 5));
    tbl.push_back(mk('0, 4, 0, 0, 0));
    tbl.push_back(mk(km(11), 5, 3, 1, 5));
    tbl.push_back(mk('0, 4, 0, 0, 0));
    tbl.push_back(mk(km(1) | km(2), 10, 0, 0, 0));
    tbl.push_back(mk(km(1), 3, 3, 0, 1));
    tbl.push_back(mk('0, 4, 0, 0, 0));
    for (int d = 1; d <= 4; d++) begin
      tbl.push_back(mk(km(d), 4, 3, 0, d));
      tbl.push_back(mk('0, 4, 0, 0, 0));
    end
    tbl.push_back(mk(km(10), 4, 0, 0, 0));
    tbl.push_back(mk('0, 4, 0, 0, 0));
    tbl.push_back(mk(km(8), 3, 3, 0, 8));
    tbl.push_back(mk(km(9), 4, 0, 0, 0));
    tbl.push_back(mk('0, 4, 0, 0, 0));
    tbl.push_back(mk(km(6), 3, 3, 0, 6));
    tbl.push_back(mk('0, 2, 0, 0, 0));
    tbl.push_back(mk(km(6), 3, 0, 0, 0));
    tbl.push_back(mk('0, 4, 0, 0, 0));
    tbl.push_back(mk(km(0), 4, 3, 0, 0));
    tbl.push_back(mk('0, 4, 0, 0, 0));

    rst  = 1'b1;
    keys = km(5);
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
    @(negedge clk);
    chk("reset_col_drv", kif.col_drv, 3'b001);
    chk("reset_key", kif.key, 0);
    chk("reset_pressed", kif.pressed, 0);
    chk("reset_set_code", kif.set_code, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_seg(tbl[i]);

    keys = km(7);
    repeat (FRAME + FRAME / 2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midreset_col_drv", kif.col_drv, 3'b001);
    chk("midreset_key", kif.key, 0);
    last_digit = 4'd0;
    run_seg(mk(km(7), 3, 3, 0, 7));
    run_seg(mk('0, 4, 0, 0, 0));

    repeat (2 * FRAME) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
